// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROL/ROR with RV64 *W-style half-width mode.
// One shift level per power of two, grouped LEVELS_PER_STAGE levels per register.
module pipe_shifter #(
  parameter int DATA_LEN         = 64,
  parameter int LEVELS_PER_STAGE = 2,
  parameter int TAG_W            = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_LEN-1:0]         din,
  input  logic [$clog2(DATA_LEN)-1:0] shamt,
  input  logic [2:0]                  op,
  input  logic                        word,
  input  logic [TAG_W-1:0]            in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_LEN-1:0]         dout,
  output logic [TAG_W-1:0]            out_tag
);

  localparam int L   = $clog2(DATA_LEN);
  localparam int LPS = LEVELS_PER_STAGE;
  localparam int NS  = (L + LPS - 1) / LPS;
  localparam int H   = DATA_LEN / 2;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  function automatic logic [DATA_LEN-1:0] f_lvl(
    input logic [DATA_LEN-1:0] d,
    input logic [2:0]          o,
    input logic                en,
    input int                  a
  );
    f_lvl = d;
    if (en) begin
      case (o)
        OP_SLL:  f_lvl = d << a;
        OP_SRL:  f_lvl = d >> a;
        OP_SRA:  f_lvl = $signed(d) >>> a;
        OP_ROL:  f_lvl = (d << a) | (d >> (DATA_LEN - a));
        OP_ROR:  f_lvl = (d >> a) | (d << (DATA_LEN - a));
        default: f_lvl = d;
      endcase
    end
  endfunction

  logic                w_stall;
  logic                w_acc;
  logic [H-1:0]        w_lo;
  logic                w_rot;
  logic                w_sra;
  logic [DATA_LEN-1:0] w_pre;
  logic [L-1:0]        w_pre_sh;

  logic                r_vld  [NS];
  logic [DATA_LEN-1:0] r_data [NS];
  logic [L-1:0]        r_sh   [NS];
  logic [2:0]          r_op   [NS];
  logic                r_word [NS];
  logic [TAG_W-1:0]    r_tag  [NS];

  logic                w_src_vld  [NS];
  logic [DATA_LEN-1:0] w_src_data [NS];
  logic [L-1:0]        w_src_sh   [NS];
  logic [2:0]          w_src_op   [NS];
  logic                w_src_word [NS];
  logic [TAG_W-1:0]    w_src_tag  [NS];
  logic [DATA_LEN-1:0] w_nxt      [NS];
  logic [DATA_LEN-1:0] w_lv       [L];

  assign out_valid = r_vld[NS-1] && !flush;
  assign w_stall   = out_valid && !out_ready;
  assign in_ready  = !w_stall && !flush;
  assign w_acc     = in_valid && in_ready;
  assign dout      = r_data[NS-1];
  assign out_tag   = r_tag[NS-1];

  assign w_lo  = din[H-1:0];
  assign w_rot = (op == OP_ROL) || (op == OP_ROR);
  assign w_sra = (op == OP_SRA);

  // Word rotates shift a doubled copy so the low half wraps within itself.
  always_comb begin
    w_pre    = din;
    w_pre_sh = shamt;
    if (word) begin
      w_pre_sh[L-1] = 1'b0;
      unique case (1'b1)
        w_rot:   w_pre = {w_lo, w_lo};
        w_sra:   w_pre = {{H{w_lo[H-1]}}, w_lo};
        default: w_pre = {{H{1'b0}}, w_lo};
      endcase
    end
  end

  assign w_src_vld[0]  = w_acc;
  assign w_src_data[0] = w_pre;
  assign w_src_sh[0]   = w_pre_sh;
  assign w_src_op[0]   = op;
  assign w_src_word[0] = word;
  assign w_src_tag[0]  = in_tag;

  for (genvar k = 1; k < NS; k++) begin : g_src
    assign w_src_vld[k]  = r_vld[k-1];
    assign w_src_data[k] = r_data[k-1];
    assign w_src_sh[k]   = r_sh[k-1];
    assign w_src_op[k]   = r_op[k-1];
    assign w_src_word[k] = r_word[k-1];
    assign w_src_tag[k]  = r_tag[k-1];
  end

  for (genvar i = 0; i < L; i++) begin : g_lvl
    localparam int S = i / LPS;
    if (i % LPS == 0) begin : g_first
      assign w_lv[i] = f_lvl(w_src_data[S], w_src_op[S],
                             w_src_sh[S][i], 1 << i);
    end else begin : g_chain
      assign w_lv[i] = f_lvl(w_lv[i-1], w_src_op[S],
                             w_src_sh[S][i], 1 << i);
    end
  end

  for (genvar k = 0; k < NS; k++) begin : g_nxt
    localparam int TOP  = (k + 1) * LPS;
    localparam int LAST = ((TOP < L) ? TOP : L) - 1;
    if (k == NS - 1) begin : g_ext
      assign w_nxt[k] = w_src_word[k]
        ? {{H{w_lv[LAST][H-1]}}, w_lv[LAST][H-1:0]}
        : w_lv[LAST];
    end else begin : g_mid
      assign w_nxt[k] = w_lv[LAST];
    end
  end

  // Stall freezes every stage, bubbles included, so order is preserved.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NS; k++) begin
        r_vld[k]  <= 1'b0;
        r_data[k] <= '0;
        r_sh[k]   <= '0;
        r_op[k]   <= '0;
        r_word[k] <= 1'b0;
        r_tag[k]  <= '0;
      end
    end else if (flush) begin
      for (int k = 0; k < NS; k++) begin
        r_vld[k] <= 1'b0;
      end
    end else if (!w_stall) begin
      for (int k = 0; k < NS; k++) begin
        r_vld[k] <= w_src_vld[k];
        if (w_src_vld[k]) begin
          r_data[k] <= w_nxt[k];
          r_sh[k]   <= w_src_sh[k];
          r_op[k]   <= w_src_op[k];
          r_word[k] <= w_src_word[k];
          r_tag[k]  <= w_src_tag[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_shifter.sv
// Directed self-checking bench for pipe_shifter (DATA_LEN=64, 3 stages).
// Each scenario task drives its own vectors and compares inline.
module tb_pipe_shifter;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] din;
  logic [5:0]  shamt;
  logic [2:0]  op;
  logic        word;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] dout;
  logic [3:0]  out_tag;

  int errors = 0;
  int checks = 0;

  pipe_shifter #(
    .DATA_LEN(64),
    .LEVELS_PER_STAGE(2),
    .TAG_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .din(din),
    .shamt(shamt),
    .op(op),
    .word(word),
    .in_tag(in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout(dout),
    .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input logic [2:0] o, input logic [63:0] d,
                      input logic [5:0] s, input logic w,
                      input logic [3:0] t, output logic rdy);
    @(negedge clk);
    op = o; din = d; shamt = s; word = w; in_tag = t;
    in_valid = 1'b1;
    #1 rdy = in_ready;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (dout !== 64'h0) begin
      errors++; $display("FAIL rst_dout: got %h want 0", dout);
    end
    checks++;
    if (out_tag !== 4'h0) begin
      errors++; $display("FAIL rst_tag: got %h want 0", out_tag);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sra;
    logic rdy;
    int n;
    send(3'b010, 64'h8000_0000_0000_0000, 6'd63, 1'b0, 4'h3, rdy);
    checks++;
    if (rdy !== 1'b1) begin
      errors++; $display("FAIL sra_first_ready: got %b want 1", rdy);
    end
    wait_out(n);
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL sra_latency: got %0d want 3", n);
    end
    checks++;
    if (dout !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL sra_dout: got %h want ffffffffffffffff", dout);
    end
    checks++;
    if (out_tag !== 4'h3) begin
      errors++; $display("FAIL sra_tag: got %h want 3", out_tag);
    end
  endtask

  task automatic test_word;
    logic rdy;
    int n;
    send(3'b000, 64'h0000_0000_4000_0001, 6'd1, 1'b1, 4'h5, rdy);
    wait_out(n);
    checks++;
    if (dout !== 64'hFFFF_FFFF_8000_0002) begin
      errors++; $display("FAIL sllw: got %h want ffffffff80000002", dout);
    end
    checks++;
    if (out_tag !== 4'h5) begin
      errors++; $display("FAIL sllw_tag: got %h want 5", out_tag);
    end
    send(3'b001, 64'h0000_0000_4000_0001, 6'd33, 1'b1, 4'h6, rdy);
    wait_out(n);
    checks++;
    if (dout !== 64'h0000_0000_2000_0000) begin
      errors++; $display("FAIL srlw: got %h want 0000000020000000", dout);
    end
    send(3'b010, 64'h0000_0000_8000_0000, 6'd4, 1'b1, 4'h7, rdy);
    wait_out(n);
    checks++;
    if (dout !== 64'hFFFF_FFFF_F800_0000) begin
      errors++; $display("FAIL sraw: got %h want fffffffff8000000", dout);
    end
  endtask

  task automatic test_rotate;
    logic rdy;
    int n;
    send(3'b100, 64'h1, 6'd1, 1'b0, 4'h1, rdy);
    wait_out(n);
    checks++;
    if (dout !== 64'h8000_0000_0000_0000) begin
      errors++; $display("FAIL ror: got %h want 8000000000000000", dout);
    end
    send(3'b011, 64'h0000_0000_8000_0000, 6'd1, 1'b1, 4'h2, rdy);
    wait_out(n);
    checks++;
    if (dout !== 64'h0000_0000_0000_0001) begin
      errors++; $display("FAIL rolw: got %h want 0000000000000001", dout);
    end
    send(3'b011, 64'hF000_0000_0000_000F, 6'd4, 1'b0, 4'h4, rdy);
    wait_out(n);
    checks++;
    if (dout !== 64'h0000_0000_0000_00FF) begin
      errors++; $display("FAIL rol: got %h want 00000000000000ff", dout);
    end
  endtask

  task automatic test_reserved;
    logic rdy;
    int n;
    send(3'b101, 64'hABCD_0000_8000_0001, 6'd4, 1'b1, 4'h8, rdy);
    wait_out(n);
    checks++;
    if (dout !== 64'hFFFF_FFFF_8000_0001) begin
      errors++; $display("FAIL resv_word: got %h want ffffffff80000001", dout);
    end
    send(3'b111, 64'h0123_4567_89AB_CDEF, 6'd9, 1'b0, 4'h9, rdy);
    wait_out(n);
    checks++;
    if (dout !== 64'h0123_4567_89AB_CDEF) begin
      errors++; $display("FAIL resv_full: got %h want 0123456789abcdef", dout);
    end
    send(3'b010, 64'h8000_0000_0000_0010, 6'd0, 1'b0, 4'hA, rdy);
    wait_out(n);
    checks++;
    if (dout !== 64'h8000_0000_0000_0010) begin
      errors++; $display("FAIL shamt0: got %h want 8000000000000010", dout);
    end
  endtask

  task automatic test_back_to_back;
    int nsent = 1;
    int nrecv = 0;
    logic [63:0] exp_d;
    logic acc, xfer;
    @(negedge clk);
    for (int cyc = 1; cyc <= 40 && nrecv < 8; cyc++) begin
      if (cyc > 1) @(negedge clk);
      out_ready = !(cyc >= 4 && cyc <= 6);
      in_valid = (nsent <= 8);
      op = 3'b000; word = 1'b0;
      din = 64'(nsent); shamt = 6'(nsent); in_tag = 4'(nsent);
      #1;
      if (cyc >= 4 && cyc <= 6) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_stall_ready c%0d: got %b want 0", cyc, in_ready);
        end
      end
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      if (xfer) begin
        exp_d = 64'(nrecv + 1) << (nrecv + 1);
        checks++;
        if (out_tag !== 4'(nrecv + 1)) begin
          errors++;
          $display("FAIL b2b_order: got %0d want %0d", out_tag, nrecv + 1);
        end
        checks++;
        if (dout !== exp_d) begin
          errors++;
          $display("FAIL b2b_data: got %h want %h", dout, exp_d);
        end
        nrecv++;
      end
      if (acc) nsent++;
    end
    checks++;
    if (nrecv != 8 || nsent != 9) begin
      errors++;
      $display("FAIL b2b_count: got recv=%0d sent=%0d want 8/9", nrecv, nsent - 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drained: got %b want 0", out_valid);
    end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      op = 3'b000; word = 1'b0; shamt = 6'd0;
      din = 64'(i + 1); in_tag = 4'(i + 1);
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_tag = 4'hF; din = 64'hDEAD;
    flush = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_gate: got valid=%b ready=%b want 0/0", out_valid, in_ready);
    end
    @(negedge clk);
    flush = 1'b0;
    din = 64'h55; shamt = 6'd1; in_tag = 4'h9;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_after1: got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      if (n < 3) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++; $display("FAIL flush_quiet n%0d: got %b want 0", n, out_valid);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 4'h9 || dout !== 64'hAA) begin
          errors++;
          $display("FAIL flush_resume: got v=%b tag=%h d=%h want 1/9/aa",
                   out_valid, out_tag, dout);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_no_leak: got %b want 0", out_valid);
    end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      op = 3'b000; word = 1'b0; shamt = 6'd4;
      din = 64'(i + 1); in_tag = 4'(i + 1);
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || dout !== 64'h10) begin
      errors++;
      $display("FAIL arst_pre: got v=%b d=%h want 1/10", out_valid, dout);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || dout !== 64'h0 || out_tag !== 4'h0) begin
      errors++;
      $display("FAIL arst_clear: got v=%b d=%h t=%h want 0/0/0",
               out_valid, dout, out_tag);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL arst_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL arst_partial n%0d: got %b want 0", n, out_valid);
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    din = '0; shamt = '0; op = '0; word = 1'b0; in_tag = '0;
    test_reset;
    test_sra;
    test_word;
    test_rotate;
    test_reserved;
    test_back_to_back;
    test_flush;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_shifter.md
PIPE_SHIFTER -- requirements
Module: pipe_shifter

Interface
REQ-001 The module SHALL have parameter DATA_LEN, default 64, giving the operand width; legal values are powers of two from 8 to 128.
REQ-002 The module SHALL have parameter LEVELS_PER_STAGE, default 2, giving the shift levels per pipeline register; legal values are 1 to $clog2(DATA_LEN).
REQ-003 The module SHALL have parameter TAG_W, default 4, giving the width of the sideband tag carried with each operation.
REQ-004 The module SHALL have port clk, input, width 1: the single clock, with all state on its rising edge.
REQ-005 The module SHALL have port rst, input, width 1: reset, asynchronous and active-high.
REQ-006 The module SHALL have port flush, input, width 1: synchronous kill of all in-flight operations.
REQ-007 The module SHALL have port in_valid, input, width 1: the request is valid.
REQ-008 The module SHALL have port in_ready, output, width 1: the request can be accepted.
REQ-009 The module SHALL have port din, input, width DATA_LEN: the operand.
REQ-010 The module SHALL have port shamt, input, width $clog2(DATA_LEN): the shift amount.
REQ-011 The module SHALL have port op, input, width 3: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; 101-111 reserved.
REQ-012 The module SHALL have port word, input, width 1: half-width (RV64 *W style) mode.
REQ-013 The module SHALL have port in_tag, input, width TAG_W: sideband data, carried unmodified.
REQ-014 The module SHALL have port out_valid, output, width 1: the result is valid.
REQ-015 The module SHALL have port out_ready, input, width 1: the consumer accepts the result.
REQ-016 The module SHALL have port dout, output, width DATA_LEN: the result.
REQ-017 The module SHALL have port out_tag, output, width TAG_W: the tag of the result.

Function
REQ-018 Shift levels SHALL number L = $clog2(DATA_LEN), and pipeline stages SHALL number NS = ceil(L / LEVELS_PER_STAGE); level i conditionally shifts by 2^i, LSB level first.
REQ-019 Latency SHALL be exactly NS cycles from the accepting edge (in_valid && in_ready) to out_valid, absent stalls.
REQ-020 Throughput SHALL be one operation per cycle.
REQ-021 Each stage SHALL hold valid, data, shamt remainder, op, word, and tag registers.
REQ-022 Global stall: stall = out_valid && !out_ready; while stall is high, every stage register (bubbles included) SHALL hold.
REQ-023 in_ready SHALL equal !stall && !flush, combinationally.
REQ-024 dout and out_tag SHALL come directly from the last stage registers; out_valid SHALL be the last-stage valid gated by !flush.
REQ-025 SLL SHALL zero-fill; SRL SHALL zero-fill; SRA SHALL fill with operand MSB; ROL and ROR SHALL rotate without loss.
REQ-026 With word=0, the operand SHALL be the full DATA_LEN bits and the full shamt SHALL apply.
REQ-027 With word=1, only din[DATA_LEN/2-1:0] SHALL be used, with MSB taken as bit DATA_LEN/2-1.
REQ-028 With word=1, shamt[L-1] SHALL be ignored, and rotation SHALL wrap within the half-width.
REQ-029 With word=1, the result SHALL be sign-extended from bit DATA_LEN/2-1 to DATA_LEN.
REQ-030 Reserved op codes SHALL produce dout = the operand unshifted, with the word-mode truncation and sign-extension still applied.
REQ-031 shamt=0 SHALL produce dout = the operand, with the word-mode rule still applied.
REQ-032 flush high at a rising edge SHALL clear every stage valid bit; no input is accepted and no output transfers in that cycle.
REQ-033 flush SHALL take priority over stall and over new input.
REQ-034 Data and tag registers SHALL update only when the stage is enabled; their content in bubbles is don't-care except after reset.

Reset
REQ-035 While rst is high, all stage valid bits, data, and tag registers SHALL be 0, so out_valid=0, dout=0, and out_tag=0.
REQ-036 While rst is high, in_ready SHALL be 1.
REQ-037 Assertion of rst mid-operation SHALL discard all in-flight operations immediately, with no partial outputs.
REQ-038 The first request SHALL be accepted on the first rising edge after rst deasserts.

Verification (DATA_LEN=64, LEVELS_PER_STAGE=2, NS=3)
REQ-039 The bench SHALL cover: SRA din=0x8000_0000_0000_0000, shamt=63, word=0 -> dout=0xFFFF_FFFF_FFFF_FFFF exactly 3 cycles after accept.
REQ-040 The bench SHALL cover: SLL din=0x0000_0000_4000_0001, shamt=1, word=1 -> dout=0xFFFF_FFFF_8000_0002; SRLW on the same din with shamt=33 (bit 5 ignored) -> 0x0000_0000_2000_0000.
REQ-041 The bench SHALL cover: ROR din=0x1, shamt=1, word=0 -> 0x8000_0000_0000_0000; ROL din=0x8000_0000, shamt=1, word=1 -> 0x0000_0000_0000_0001.
REQ-042 The bench SHALL cover: back-to-back requests with tags 1..8 and out_ready held low for cycles 4-6 -> in_ready=0 during the stall, no request lost or duplicated, and results emerge in tag order 1..8.
REQ-043 The bench SHALL cover: three requests in flight, then flush pulsed for 1 cycle -> out_valid stays 0 for the following 3 cycles, and a request accepted the cycle after flush emerges 3 cycles later.
REQ-044 The bench SHALL cover: rst asserted asynchronously mid-stream with out_ready=1 -> out_valid=0 and dout=0 before the next clock edge, and in_ready=1.
